// File: rtl/pb_debounce.sv
// +----------------------------------------------------------------------------+
// | Module      : pb_debounce                                                  |
// | Description : Two-channel push-button conditioner for the tug-of-war game. |
// |               Synchronises, debounces with a stable-count FSM, emits       |
// |               press/release pulses and flags near-simultaneous presses.    |
// |               Optional stuck-button detection is enabled by defining the   |
// |               macro PB_STUCK_DETECT_EN.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pb_debounce #(
  parameter int DB_CYCLES    = 5,
  parameter int TIE_WIN      = 2,
  parameter int STUCK_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl_raw,
  input  logic       pbr_raw,
  output logic       pbl,
  output logic       pbr,
  output logic       pbl_rise,
  output logic       pbr_rise,
  output logic       pbl_fall,
  output logic       pbr_fall,
  output logic       tie_pulse,
  output logic [1:0] stuck
);

  typedef enum logic [1:0] {
    ST_REL   = 2'd0,
    ST_PWAIT = 2'd1,
    ST_PRS   = 2'd2,
    ST_RWAIT = 2'd3
  } state_t;

  localparam logic [7:0] c_db_last = 8'(DB_CYCLES - 1);
  localparam logic [7:0] c_tie_win = 8'(TIE_WIN);

  // Reject out-of-range configurations at elaboration.
  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_range_err
    $error("pb_debounce: DB_CYCLES out of range 1..255");
  end
  if (TIE_WIN < 0 || TIE_WIN > 255) begin : g_tie_range_err
    $error("pb_debounce: TIE_WIN out of range 0..255");
  end
  if (STUCK_CYCLES < 1) begin : g_stuck_range_err
    $error("pb_debounce: STUCK_CYCLES must be at least 1");
  end

  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_rise;
  logic [1:0] w_fall;
  logic [1:0] w_stuck;

  assign w_raw = {pbr_raw, pbl_raw};

  // Channel 0 is left, channel 1 is right.
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic       r_sync1;
    logic       r_sync2;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_level_q;
    logic       w_stuck_cur;
    logic       w_stuck_set;
    logic       w_stuck_clr;
    logic       w_hold_full;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_raw[i];
        r_sync2 <= r_sync1;
      end
    end

`ifdef PB_STUCK_DETECT_EN
    localparam int              c_hold_w     = $clog2(STUCK_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(STUCK_CYCLES - 1);
    logic [c_hold_w-1:0] r_hold;
    logic                r_stuck;

    // Saturating count of cycles spent in an accepted-press state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_hold <= '0;
      end else if (r_state == ST_PRS || r_state == ST_RWAIT) begin
        if (r_hold != c_hold_last) r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end
    end

    assign w_hold_full = (r_state == ST_PRS || r_state == ST_RWAIT) &&
                         (r_hold == c_hold_last);

    // Stuck flag: set by the forced exit, cleared after a stable release.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)             r_stuck <= 1'b0;
      else if (w_stuck_set) r_stuck <= 1'b1;
      else if (w_stuck_clr) r_stuck <= 1'b0;
    end

    assign w_stuck_cur = r_stuck;
`else
    assign w_hold_full = 1'b0;
    assign w_stuck_cur = 1'b0;
`endif

    // Debounce FSM state and stable-sample counter.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state   <= ST_REL;
        r_cnt     <= 8'd0;
        r_level_q <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level_q <= w_level[i];
      end
    end

    // Next-state logic; a stuck channel uses REL's counter to time the release.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stuck_set = 1'b0;
      w_stuck_clr = 1'b0;
      case (r_state)
        ST_REL: begin
          if (w_stuck_cur) begin
            if (r_sync2) begin
              w_cnt_nxt = 8'd0;
            end else if (r_cnt == c_db_last) begin
              w_cnt_nxt   = 8'd0;
              w_stuck_clr = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end else if (r_sync2) begin
            if (DB_CYCLES == 1) begin
              w_state_nxt = ST_PRS;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_state_nxt = ST_PWAIT;
              w_cnt_nxt   = 8'd1;
            end
          end
        end
        ST_PWAIT: begin
          if (!r_sync2) begin
            w_state_nxt = ST_REL;
            w_cnt_nxt   = 8'd0;
          end else if (r_cnt == c_db_last) begin
            w_state_nxt = ST_PRS;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        ST_PRS: begin
          if (!r_sync2) begin
            if (DB_CYCLES == 1) begin
              w_state_nxt = ST_REL;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_state_nxt = ST_RWAIT;
              w_cnt_nxt   = 8'd1;
            end
          end
        end
        ST_RWAIT: begin
          if (r_sync2) begin
            w_state_nxt = ST_PRS;
            w_cnt_nxt   = 8'd0;
          end else if (r_cnt == c_db_last) begin
            w_state_nxt = ST_REL;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_REL;
          w_cnt_nxt   = 8'd0;
        end
      endcase
      if (w_hold_full) begin
        w_state_nxt = ST_REL;
        w_cnt_nxt   = 8'd0;
        w_stuck_set = 1'b1;
      end
    end

    assign w_level[i] = (r_state == ST_PRS) || (r_state == ST_RWAIT);
    assign w_rise[i]  = w_level[i] & ~r_level_q;
    // A forced stuck exit drops the level with the stuck flag already set.
    assign w_fall[i]  = ~w_level[i] & r_level_q & ~w_stuck_cur;
    assign w_stuck[i] = w_stuck_cur;
  end

  logic [1:0] w_rise_ok;
  logic       w_tie;
  logic       r_win_open;
  logic       r_win_side;
  logic [7:0] r_dist;

  assign w_rise_ok = w_rise & ~w_stuck;

  // r_dist is the distance in cycles from the opening rise to the current cycle.
  assign w_tie = (w_rise_ok[0] & w_rise_ok[1]) |
                 (r_win_open && (r_dist <= c_tie_win) &&
                  ((!r_win_side && w_rise_ok[1]) || (r_win_side && w_rise_ok[0])));

  // Tie window: opens on a first rise, closes on a tie or after TIE_WIN cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_open <= 1'b0;
      r_win_side <= 1'b0;
      r_dist     <= 8'd0;
    end else if (w_tie) begin
      r_win_open <= 1'b0;
    end else if (!r_win_open) begin
      if (|w_rise_ok) begin
        r_win_open <= (TIE_WIN != 0);
        r_win_side <= w_rise_ok[1];
        r_dist     <= 8'd1;
      end
    end else if (r_dist >= c_tie_win) begin
      r_win_open <= 1'b0;
    end else begin
      r_dist <= r_dist + 8'd1;
    end
  end

  assign pbl       = w_level[0];
  assign pbr       = w_level[1];
  assign pbl_rise  = w_rise[0];
  assign pbr_rise  = w_rise[1];
  assign pbl_fall  = w_fall[0];
  assign pbr_fall  = w_fall[1];
  assign tie_pulse = w_tie;
  assign stuck     = w_stuck;

endmodule

`default_nettype wire

// File: tb/tb_pb_debounce.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pb_debounce                                               |
// | Description : Directed self-checking bench for pb_debounce (DB_CYCLES=5,   |
// |               TIE_WIN=2, STUCK_CYCLES=20). Stuck scenario follows the      |
// |               PB_STUCK_DETECT_EN macro.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pb_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pbl_raw = 1'b0;
  logic       pbr_raw = 1'b0;
  logic       pbl, pbr, pbl_rise, pbr_rise, pbl_fall, pbr_fall, tie_pulse;
  logic [1:0] stuck;

  int checks   = 0;
  int failures = 0;

  pb_debounce #(
    .DB_CYCLES   (5),
    .TIE_WIN     (2),
    .STUCK_CYCLES(20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pbl_raw  (pbl_raw),
    .pbr_raw  (pbr_raw),
    .pbl      (pbl),
    .pbr      (pbr),
    .pbl_rise (pbl_rise),
    .pbr_rise (pbr_rise),
    .pbl_fall (pbl_fall),
    .pbr_fall (pbr_fall),
    .tie_pulse(tie_pulse),
    .stuck    (stuck)
  );

  always #5 clk = ~clk;

  // Output bundle: {pbl,pbr,pbl_rise,pbr_rise,pbl_fall,pbr_fall,tie,stuck[1:0]}
  function automatic logic [8:0] outs();
    return {pbl, pbr, pbl_rise, pbr_rise, pbl_fall, pbr_fall, tie_pulse, stuck};
  endfunction

  // Advance n rising edges; sample point is 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first_hi;
    int rises;
    int ties;
    int ties_on_r;
    int bad;
    logic [4:0] pat;

    // Reset
    tick(3);
    chk("reset_outs", 32'(outs()), 32'h000);
    rst = 1'b1;
    tick(2);
    chk("idle_outs", 32'(outs()), 32'h000);

    // Clean left press: level after 7 edges, one rise pulse
    pbl_raw = 1'b1;
    tick(6);
    chk("clean_pre7", 32'(outs()), 32'h000);
    tick(1);
    chk("clean_edge7", 32'(outs()), 32'(9'b1_0_1_0_0_0_0_00));
    tick(1);
    chk("clean_edge8", 32'(outs()), 32'(9'b1_0_0_0_0_0_0_00));
    // Clean release
    pbl_raw = 1'b0;
    tick(6);
    chk("rel_pre7", 32'(outs()), 32'(9'b1_0_0_0_0_0_0_00));
    tick(1);
    chk("rel_edge7", 32'(outs()), 32'(9'b0_0_0_0_1_0_0_00));
    tick(1);
    chk("rel_edge8", 32'(outs()), 32'h000);
    tick(5);

    // Bouncy press: samples 1,0,1,1,0 then steady 1
    pat = 5'b01101;
    first_hi = -1;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      pbl_raw = (i < 5) ? pat[i] : 1'b1;
      tick(1);
      if (pbl_rise) rises++;
      if (pbl && first_hi < 0) first_hi = i + 1;
    end
    chk("bounce_first_edge", 32'(first_hi), 32'd12);
    chk("bounce_rises", 32'(rises), 32'd1);
    pbl_raw = 1'b0;
    tick(12);
    chk("bounce_released", 32'(outs()), 32'h000);

    // Simultaneous presses: tie with both rises
    pbl_raw = 1'b1;
    pbr_raw = 1'b1;
    tick(7);
    chk("tie_same_cycle", 32'(outs()), 32'(9'b1_1_1_1_0_0_1_00));
    tick(1);
    chk("tie_same_after", 32'(outs()), 32'(9'b1_1_0_0_0_0_0_00));
    pbl_raw = 1'b0;
    pbr_raw = 1'b0;
    tick(12);

    // Right two cycles late: one tie, coincident with pbr_rise
    ties = 0;
    ties_on_r = 0;
    pbl_raw = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) pbr_raw = 1'b1;
      tick(1);
      if (tie_pulse) ties++;
      if (tie_pulse && pbr_rise) ties_on_r++;
    end
    chk("tie_late2_count", 32'(ties), 32'd1);
    chk("tie_late2_on_rise", 32'(ties_on_r), 32'd1);
    pbl_raw = 1'b0;
    pbr_raw = 1'b0;
    tick(12);

    // Right three cycles late: no tie
    ties = 0;
    rises = 0;
    pbl_raw = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) pbr_raw = 1'b1;
      tick(1);
      if (tie_pulse) ties++;
      if (pbr_rise) rises++;
    end
    chk("tie_late3_count", 32'(ties), 32'd0);
    chk("tie_late3_rrise", 32'(rises), 32'd1);
    pbl_raw = 1'b0;
    pbr_raw = 1'b0;
    tick(12);

    // Asynchronous reset mid-debounce, with right already pressed
    pbr_raw = 1'b1;
    tick(10);
    pbl_raw = 1'b1;
    tick(5);
    chk("pre_reset_outs", 32'(outs()), 32'(9'b0_1_0_0_0_0_0_00));
    rst = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'h000);
    tick(1);
    rst = 1'b1;
    tick(6);
    chk("post_reset_pre7", 32'(outs()), 32'h000);
    tick(1);
    chk("post_reset_edge7", 32'(outs()), 32'(9'b1_1_1_1_0_0_1_00));
    pbl_raw = 1'b0;
    pbr_raw = 1'b0;
    tick(12);

`ifdef PB_STUCK_DETECT_EN
    // Held button: accepted at edge 7, forced out at edge 27 without a fall
    pbl_raw = 1'b1;
    tick(26);
    chk("stuck_edge26", 32'(outs()), 32'(9'b1_0_0_0_0_0_0_00));
    tick(1);
    chk("stuck_edge27", 32'(outs()), 32'(9'b0_0_0_0_0_0_0_01));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (outs() !== 9'b0_0_0_0_0_0_0_01) bad++;
    end
    chk("stuck_hold_quiet", 32'(bad), 32'd0);
    pbl_raw = 1'b0;
    tick(6);
    chk("stuck_clr_pre7", 32'(stuck), 32'd1);
    tick(1);
    chk("stuck_clr_edge7", 32'(outs()), 32'h000);
    pbl_raw = 1'b1;
    tick(6);
    chk("stuck_repress_pre7", 32'(outs()), 32'h000);
    tick(1);
    chk("stuck_repress_edge7", 32'(outs()), 32'(9'b1_0_1_0_0_0_0_00));
`else
    // Held button without stuck detection: level stays high
    pbl_raw = 1'b1;
    tick(7);
    chk("hold_accept", 32'(outs()), 32'(9'b1_0_1_0_0_0_0_00));
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (outs() !== 9'b1_0_0_0_0_0_0_00) bad++;
    end
    chk("hold_100_level", 32'(bad), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
